alu_share_arbiter: RTL

//   Shares one combinational ALU between two requesters (port 0: EX-stage, port 1: auxiliary unit).

---
 rtl/alu_share_arbiter_if.sv | 25 ++
 rtl/alu_share_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle for the shared ALU arbiter:
// request handshake with operands, and response handshake with result.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters,
// with registered operands toward the ALU and registered results back.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arbiter_if.slave p0,
  alu_share_arbiter_if.slave p1,
  input  logic              flush,
  output logic [OP_W-1:0]   alu_option,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic [DATA_W-1:0] res0;
  logic [DATA_W-1:0] res1;

  logic              rsp_done;
  logic              open;
  logic              gnt_any;
  logic              gnt;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  // A grant slot opens in IDLE, or in RESP once the owner takes its result.
  always_comb begin
    rsp_done = 1'b0;
    if (state == RESP)
      rsp_done = owner ? p1.rsp_ready : p0.rsp_ready;
    open    = !flush && (state == IDLE || rsp_done);
    gnt_any = open && (p0.req_valid || p1.req_valid);
    if (p0.req_valid && p1.req_valid)
      gnt = ~last_grant;
    else
      gnt = p1.req_valid;
    sel_op = gnt ? p1.req_op : p0.req_op;
    sel_a  = gnt ? p1.req_a  : p0.req_a;
    sel_b  = gnt ? p1.req_b  : p0.req_b;
  end

  assign p0.req_ready  = gnt_any && !gnt;
  assign p1.req_ready  = gnt_any && gnt;
  assign p0.rsp_valid  = (state == RESP) && !owner;
  assign p1.rsp_valid  = (state == RESP) && owner;
  assign p0.rsp_result = res0;
  assign p1.rsp_result = res1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_option <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      res0       <= '0;
      res1       <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE, RESP: begin
          if (gnt_any) begin
            owner      <= gnt;
            last_grant <= gnt;
            alu_option <= sel_op;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            state      <= EXEC;
          end else if (rsp_done) begin
            state <= IDLE;
          end
        end
        EXEC: begin
          if (owner)
            res1 <= alu_result;
          else
            res0 <= alu_result;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
